reg_bank_sequencer: RTL and testbench
=====================================

// Module: reg_bank_sequencer
// PURPOSE
//  Sequences a bank of NUM_REGS 8-bit REG blocks for one operation at a time.
//  Accepts an op (src1, src2, dst, wb_en) over a valid/ready handshake and drives each REG's control lines:
//  - Load: selects the Output_1 / operand-A bus.
//  - Input: selects the Output_2 / operand-B bus.
//  - Save: commits the writeback bus.
//  Sits between the instruction decoder and the register bank. The ALU is handshaked through exec_start/exec_done.
// PARAMETERS
//  NUM_REGS      6   number of REG instances controlled (1..8)
//  SEL_W         3   width of register index fields
//  EXEC_TIMEOUT  15  max cycles in EXEC awaiting exec_done before abort (1..255)
// PORTS
//  clk        in   1         clock, rising edge
//  rst        in   1         asynchronous active-high reset
//  op_valid   in   1         op fields valid
//  op_ready   out  1         sequencer can accept op (IDLE only)
//  op_src1    in   SEL_W     register driven onto operand-A bus (Load)
//  op_src2    in   SEL_W     register driven onto operand-B bus (Input)
//  op_dst     in   SEL_W     writeback register (Save)
//  op_wb_en   in   1         1 = perform writeback
//  exec_start out  1         one-cycle pulse on EXEC entry
//  exec_done  in   1         ALU result valid on writeback bus
//  reg_load   out  NUM_REGS  one-hot-or-zero, to REG.Load
//  reg_input  out  NUM_REGS  one-hot-or-zero, to REG.Input
//  reg_save   out  NUM_REGS  one-hot-or-zero, to REG.Save
//  busy       out  1         state != IDLE
//  timeout    out  1         one-cycle pulse on EXEC abort
//  sel_err    out  1         sticky: an accepted op had an index >= NUM_REGS
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, all outputs 0 except op_ready=1, sel_err=0, timeout counter=0, latched op cleared.
//  - States and transitions:
//    - IDLE: op_ready=1. On op_valid&op_ready, latch fields, go to READ.
//    - READ: reg_load[src1] and reg_input[src2] asserted. Exactly 1 cycle, then go to EXEC.
//    - EXEC: read enables stay asserted. exec_start=1 on the first EXEC cycle only. The counter increments every EXEC cycle.
//      - exec_done=1: go to WB if wb_en, else IDLE.
//      - counter reaches EXEC_TIMEOUT without exec_done: pulse timeout, go to IDLE, no save.
//    - WB: reg_save[dst]=1 for exactly 1 cycle, read enables held, then go to IDLE. The REG captures its Save_value at the clock edge ending WB.
//  - Latency, accept to save: 2 + (EXEC cycles incl. done) + 1. The minimum is 4 cycles with exec_done on the first EXEC cycle.
//  - Throughput: op_ready is low from READ through WB. The next op is accepted on the IDLE cycle after completion.
//  - Index rules:
//    - Index >= NUM_REGS selects no register, so the corresponding vector is all-zero (external source/sink).
//    - sel_err is set at acceptance if any field used by the op is out of range. It is cleared only by rst. dst is checked only if wb_en.
//  - src1==src2: the same bit is set in both reg_load and reg_input (legal, independent switches).
//  - dst==src1/src2: legal. Reads stay enabled during WB; the new value is visible after the WB edge.
//  - wb_en=0: WB is skipped and reg_save never asserts.
//  - exec_done outside EXEC is ignored. A stale exec_done does not skip EXEC.
//  - Output vectors are registered from state and latched fields, so they are glitch-free. At most one bit is set per vector.
// TESTING
//  1. Basic op: src1=1, src2=2, dst=3, wb_en=1, exec_done on 2nd EXEC cycle. Required response:
//     - reg_load=000010 and reg_input=000100 from READ through WB.
//     - reg_save=001000 for 1 cycle.
//     - Accept to save = 5 cycles, then op_ready=1.
//  2. No writeback: wb_en=0, exec_done on 1st EXEC cycle. Required response: reg_save stays 000000; back in IDLE 3 cycles after accept.
//  3. Timeout: exec_done held 0. Required response:
//     - timeout pulses after 15 EXEC cycles.
//     - reg_save never asserts; all vectors 0 next cycle; op_ready=1.
//  4. Out-of-range index: src1=7, src2=0, dst=6, wb_en=1 (NUM_REGS=6). Required response:
//     - reg_load=0, reg_input=000001, reg_save=0 in WB.
//     - sel_err=1 and stays set until rst.
//  5. Mid-op reset: assert rst during EXEC, then again during WB. Required response:
//     - All vectors 0 immediately (async), no save edge, state IDLE, op_ready=1.
//  6. Back-to-back ops: op_valid held high with 3 queued ops, src1==src2==dst=4. Required response:
//     - Each op is accepted only in IDLE.
//     - reg_load and reg_input both 010000 during each op.
//     - 3 save pulses total.

Source files
------------

// File: rtl/reg_bank_sequencer.sv
// Register-bank sequencer: drives REG Load/Input/Save strobes for one op
// at a time, handshaking the ALU through exec_start/exec_done.
module reg_bank_sequencer #(
  parameter int NUM_REGS     = 6,
  parameter int SEL_W        = 3,
  parameter int EXEC_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [SEL_W-1:0]    op_src1,
  input  logic [SEL_W-1:0]    op_src2,
  input  logic [SEL_W-1:0]    op_dst,
  input  logic                op_wb_en,
  output logic                exec_start,
  input  logic                exec_done,
  output logic [NUM_REGS-1:0] reg_load,
  output logic [NUM_REGS-1:0] reg_input,
  output logic [NUM_REGS-1:0] reg_save,
  output logic                busy,
  output logic                timeout,
  output logic                sel_err
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EXEC,
    WB
  } state_t;

  localparam logic [SEL_W:0] NR    = (SEL_W+1)'(NUM_REGS);
  localparam logic [7:0]     TLAST = 8'(EXEC_TIMEOUT - 1);

  state_t           state;
  logic [SEL_W-1:0] src1_q;
  logic [SEL_W-1:0] src2_q;
  logic [SEL_W-1:0] dst_q;
  logic             wb_q;
  logic [7:0]       cnt;

  // Out-of-range indices decode to all-zero (external source/sink).
  function automatic logic [NUM_REGS-1:0] dec(
    input logic [SEL_W-1:0] i
  );
    logic [NUM_REGS-1:0] d;
    d = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if ({1'b0, i} == (SEL_W+1)'(k))
        d[k] = 1'b1;
    return d;
  endfunction

  function automatic logic oor(
    input logic [SEL_W-1:0] i
  );
    return {1'b0, i} >= NR;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      src1_q     <= '0;
      src2_q     <= '0;
      dst_q      <= '0;
      wb_q       <= 1'b0;
      cnt        <= '0;
      op_ready   <= 1'b1;
      exec_start <= 1'b0;
      reg_load   <= '0;
      reg_input  <= '0;
      reg_save   <= '0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
      sel_err    <= 1'b0;
    end else begin
      exec_start <= 1'b0;
      timeout    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (op_valid && op_ready) begin
            state     <= READ;
            src1_q    <= op_src1;
            src2_q    <= op_src2;
            dst_q     <= op_dst;
            wb_q      <= op_wb_en;
            op_ready  <= 1'b0;
            busy      <= 1'b1;
            reg_load  <= dec(op_src1);
            reg_input <= dec(op_src2);
            if (oor(op_src1) || oor(op_src2) ||
                (op_wb_en && oor(op_dst)))
              sel_err <= 1'b1;
          end
        end
        READ: begin
          state      <= EXEC;
          exec_start <= 1'b1;
          cnt        <= '0;
        end
        EXEC: begin
          cnt <= cnt + 8'd1;
          if (exec_done) begin
            if (wb_q) begin
              state    <= WB;
              reg_save <= dec(dst_q);
            end else begin
              state     <= IDLE;
              op_ready  <= 1'b1;
              busy      <= 1'b0;
              reg_load  <= '0;
              reg_input <= '0;
            end
          end else if (cnt == TLAST) begin
            state     <= IDLE;
            timeout   <= 1'b1;
            op_ready  <= 1'b1;
            busy      <= 1'b0;
            reg_load  <= '0;
            reg_input <= '0;
          end
        end
        WB: begin
          state     <= IDLE;
          reg_save  <= '0;
          op_ready  <= 1'b1;
          busy      <= 1'b0;
          reg_load  <= '0;
          reg_input <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank_sequencer.sv
// Directed bench for reg_bank_sequencer with hand-computed expectations.
module tb_reg_bank_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [2:0] op_src1 = '0;
  logic [2:0] op_src2 = '0;
  logic [2:0] op_dst = '0;
  logic       op_wb_en = 1'b0;
  logic       exec_start;
  logic       exec_done = 1'b0;
  logic [5:0] reg_load;
  logic [5:0] reg_input;
  logic [5:0] reg_save;
  logic       busy;
  logic       timeout;
  logic       sel_err;

  int n_chk = 0;
  int n_pass = 0;
  int done_at = 0;
  int ecnt = 0;

  reg_bank_sequencer #(
    .NUM_REGS(6),
    .SEL_W(3),
    .EXEC_TIMEOUT(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .op_valid(op_valid),
    .op_ready(op_ready),
    .op_src1(op_src1),
    .op_src2(op_src2),
    .op_dst(op_dst),
    .op_wb_en(op_wb_en),
    .exec_start(exec_start),
    .exec_done(exec_done),
    .reg_load(reg_load),
    .reg_input(reg_input),
    .reg_save(reg_save),
    .busy(busy),
    .timeout(timeout),
    .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  // ALU stand-in: raise exec_done on the done_at-th EXEC cycle.
  always @(negedge clk) begin
    if (exec_start) ecnt = 1;
    else if (busy && ecnt != 0) ecnt = ecnt + 1;
    else if (!busy) ecnt = 0;
    exec_done = (done_at != 0) && (ecnt == done_at);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Present op at a negedge; returns at the READ-cycle negedge.
  task automatic issue(input logic [2:0] s1, input logic [2:0] s2,
                       input logic [2:0] d, input logic wb,
                       input int da);
    done_at  = da;
    op_src1  = s1;
    op_src2  = s2;
    op_dst   = d;
    op_wb_en = wb;
    op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  // Cycle index: accept cycle = 1, READ = 2, ...
  task automatic run_op(input logic [2:0] s1, input logic [2:0] s2,
                        input logic [2:0] d, input logic wb,
                        input int da,
                        input logic [5:0] el, input logic [5:0] ei,
                        input logic [5:0] es,
                        output int save_cyc, output int idle_cyc,
                        output int save_cnt, output int bad);
    int n;
    issue(s1, s2, d, wb, da);
    n = 2;
    save_cyc = 0;
    save_cnt = 0;
    bad = 0;
    while (busy && n < 40) begin
      if (reg_load !== el || reg_input !== ei || op_ready) bad++;
      if (reg_save != 0) begin
        save_cnt++;
        save_cyc = n;
        if (reg_save !== es) bad++;
      end
      @(negedge clk);
      n++;
    end
    idle_cyc = n;
  endtask

  initial begin
    int sc, ic, sn, bad, acc, saves;
    logic drop;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(op_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_vecs", 32'({reg_load, reg_input, reg_save}), 32'd0);
    chk("rst_flags", 32'({exec_start, timeout, sel_err}), 32'd0);

    // Basic op, exec_done on 2nd EXEC cycle
    issue(3'd1, 3'd2, 3'd3, 1'b1, 2);
    chk("t1_read_load", 32'(reg_load), 32'b000010);
    chk("t1_read_input", 32'(reg_input), 32'b000100);
    chk("t1_read_ready", 32'(op_ready), 32'd0);
    chk("t1_read_start", 32'(exec_start), 32'd0);
    @(negedge clk);
    chk("t1_e1_start", 32'(exec_start), 32'd1);
    @(negedge clk);
    chk("t1_e2_start", 32'(exec_start), 32'd0);
    chk("t1_e2_save", 32'(reg_save), 32'd0);
    @(negedge clk);
    chk("t1_wb_save", 32'(reg_save), 32'b001000);
    chk("t1_wb_load", 32'(reg_load), 32'b000010);
    chk("t1_wb_input", 32'(reg_input), 32'b000100);
    @(negedge clk);
    chk("t1_idle_vecs", 32'({reg_load, reg_input, reg_save}), 32'd0);
    chk("t1_idle_ready", 32'(op_ready), 32'd1);

    // Same op through the monitor loop for latency
    run_op(3'd1, 3'd2, 3'd3, 1'b1, 2, 6'b000010, 6'b000100,
           6'b001000, sc, ic, sn, bad);
    chk("t1_lat", 32'(sc), 32'd5);
    chk("t1_saves", 32'(sn), 32'd1);
    chk("t1_vec_err", 32'(bad), 32'd0);

    // No writeback
    run_op(3'd0, 3'd5, 3'd2, 1'b0, 1, 6'b000001, 6'b100000,
           6'b000000, sc, ic, sn, bad);
    chk("t2_saves", 32'(sn), 32'd0);
    chk("t2_idle_after", 32'(ic - 1), 32'd3);
    chk("t2_vec_err", 32'(bad), 32'd0);
    chk("t2_ready", 32'(op_ready), 32'd1);

    // Timeout
    run_op(3'd2, 3'd3, 3'd4, 1'b1, 0, 6'b000100, 6'b001000,
           6'b000000, sc, ic, sn, bad);
    chk("t3_exec_cycles", 32'(ic - 3), 32'd15);
    chk("t3_pulse", 32'(timeout), 32'd1);
    chk("t3_saves", 32'(sn), 32'd0);
    chk("t3_vecs", 32'({reg_load, reg_input, reg_save}), 32'd0);
    chk("t3_ready", 32'(op_ready), 32'd1);
    chk("t3_vec_err", 32'(bad), 32'd0);
    @(negedge clk);
    chk("t3_pulse_end", 32'(timeout), 32'd0);
    chk("t3_sel_err", 32'(sel_err), 32'd0);

    // Out-of-range indices
    run_op(3'd7, 3'd0, 3'd6, 1'b1, 1, 6'b000000, 6'b000001,
           6'b000000, sc, ic, sn, bad);
    chk("t4_vec_err", 32'(bad), 32'd0);
    chk("t4_saves", 32'(sn), 32'd0);
    chk("t4_wb_visited", 32'(ic), 32'd5);
    chk("t4_sel_err", 32'(sel_err), 32'd1);
    run_op(3'd1, 3'd1, 3'd1, 1'b1, 1, 6'b000010, 6'b000010,
           6'b000010, sc, ic, sn, bad);
    chk("t4_sel_sticky", 32'(sel_err), 32'd1);
    chk("t4_next_saves", 32'(sn), 32'd1);

    // Reset during EXEC
    issue(3'd3, 3'd4, 3'd5, 1'b1, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5e_vecs", 32'({reg_load, reg_input, reg_save}), 32'd0);
    chk("t5e_ready", 32'(op_ready), 32'd1);
    chk("t5e_busy", 32'(busy), 32'd0);
    chk("t5e_sel_err", 32'(sel_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Reset during WB
    issue(3'd3, 3'd4, 3'd5, 1'b1, 1);
    @(negedge clk);
    @(negedge clk);
    chk("t5w_save_pre", 32'(reg_save), 32'b100000);
    rst = 1'b1;
    #1;
    chk("t5w_vecs", 32'({reg_load, reg_input, reg_save}), 32'd0);
    chk("t5w_ready", 32'(op_ready), 32'd1);
    chk("t5w_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("t5w_idle_hold", 32'({busy, op_ready}), 32'b01);

    // Back-to-back ops with op_valid held high
    done_at  = 1;
    op_src1  = 3'd4;
    op_src2  = 3'd4;
    op_dst   = 3'd4;
    op_wb_en = 1'b1;
    op_valid = 1'b1;
    acc = op_ready ? 1 : 0;
    saves = 0;
    bad = 0;
    drop = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (drop) op_valid = 1'b0;
      if (busy) begin
        if (op_ready) bad++;
        if (reg_load !== 6'b010000 || reg_input !== 6'b010000) bad++;
        if (reg_save == 6'b010000) saves++;
        else if (reg_save != 0) bad++;
      end
      if (op_ready && op_valid) begin
        acc++;
        if (acc == 3) drop = 1'b1;
      end
    end
    chk("t6_accepts", 32'(acc), 32'd3);
    chk("t6_saves", 32'(saves), 32'd3);
    chk("t6_vec_err", 32'(bad), 32'd0);
    chk("t6_idle", 32'({busy, op_ready}), 32'b01);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
